// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: register write-back plus RET/RTI stack-pop reassembly
module writeback_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int FLAG_WIDTH     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [1:0]                wb_src_select,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rdst,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic [DATA_WIDTH-1:0]     in_port,
  input  logic                      pop_start,
  input  logic                      pop_kind,
  input  logic                      mem_data_valid,
  output logic                      rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      pc_load,
  output logic [PC_WIDTH-1:0]       pc_value,
  output logic                      flags_load,
  output logic [FLAG_WIDTH-1:0]     flags_value,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP_FLAGS = 2'd1,
    POP_PC_LO = 2'd2,
    POP_PC_HI = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_is_rti;
  logic [DATA_WIDTH-1:0]   r_pc_lo;
  logic [FLAG_WIDTH-1:0]   r_flags_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_is_rti        <= 1'b0;
      r_pc_lo         <= '0;
      r_flags_hold    <= '0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      pc_load         <= 1'b0;
      pc_value        <= '0;
      flags_load      <= 1'b0;
      flags_value     <= '0;
      busy            <= 1'b0;
    end else begin
      rf_write_enable <= 1'b0;
      pc_load         <= 1'b0;
      flags_load      <= 1'b0;
      case (r_state)
        IDLE: begin
          // A pop outranks a same-cycle write-back; the write is dropped.
          if (pop_start) begin
            r_is_rti <= pop_kind;
            busy     <= 1'b1;
            r_state  <= pop_kind ? POP_FLAGS : POP_PC_LO;
          end else if (wb_valid && wb_src_select != 2'b11) begin
            rf_write_enable <= 1'b1;
            rf_write_addr   <= wb_rdst;
            case (wb_src_select)
              2'b00:   rf_write_data <= alu_result;
              2'b01:   rf_write_data <= mem_data;
              default: rf_write_data <= in_port;
            endcase
          end
        end
        POP_FLAGS: begin
          if (mem_data_valid) begin
            r_flags_hold <= mem_data[FLAG_WIDTH-1:0];
            r_state      <= POP_PC_LO;
          end
        end
        POP_PC_LO: begin
          if (mem_data_valid) begin
            r_pc_lo <= mem_data;
            r_state <= POP_PC_HI;
          end
        end
        POP_PC_HI: begin
          if (mem_data_valid) begin
            pc_value <= {mem_data, r_pc_lo};
            pc_load  <= 1'b1;
            if (r_is_rti) begin
              flags_value <= r_flags_hold;
              flags_load  <= 1'b1;
            end
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [1:0]  wb_src_select;
  logic [2:0]  wb_rdst;
  logic [15:0] alu_result;
  logic [15:0] mem_data;
  logic [15:0] in_port;
  logic        pop_start;
  logic        pop_kind;
  logic        mem_data_valid;
  logic        rf_write_enable;
  logic [2:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        flags_load;
  logic [2:0]  flags_value;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_src_select(wb_src_select),
    .wb_rdst(wb_rdst), .alu_result(alu_result), .mem_data(mem_data), .in_port(in_port),
    .pop_start(pop_start), .pop_kind(pop_kind), .mem_data_valid(mem_data_valid),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .pc_load(pc_load), .pc_value(pc_value),
    .flags_load(flags_load), .flags_value(flags_value), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_valid = 0; wb_src_select = 0; wb_rdst = 0; alu_result = 0;
    mem_data = 0; in_port = 0; pop_start = 0; pop_kind = 0; mem_data_valid = 0;
    step(); step();
    reset = 1'b0;
    n_cmp++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== 20'h0) begin
      n_fail++; $display("FAIL reset_rf: got %h want 0", {rf_write_enable, rf_write_addr, rf_write_data});
    end
    n_cmp++;
    if ({pc_load, pc_value, flags_load, flags_value, busy} !== 38'h0) begin
      n_fail++; $display("FAIL reset_pop: got %h want 0", {pc_load, pc_value, flags_load, flags_value, busy});
    end
  endtask

  task automatic test_writeback();
    wb_valid = 1; wb_src_select = 2'b00; wb_rdst = 3'd5; alu_result = 16'h1234;
    step();
    wb_valid = 0;
    n_cmp++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd5, 16'h1234}) begin
      n_fail++; $display("FAIL wb_alu: got %b/%0d/%h want 1/5/1234", rf_write_enable, rf_write_addr, rf_write_data);
    end
    step();
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL wb_strobe_drop: got %b want 0", rf_write_enable);
    end
    wb_valid = 1; wb_src_select = 2'b01; wb_rdst = 3'd2; mem_data = 16'hBEEF;
    step();
    n_cmp++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd2, 16'hBEEF}) begin
      n_fail++; $display("FAIL wb_mem: got %b/%0d/%h want 1/2/beef", rf_write_enable, rf_write_addr, rf_write_data);
    end
    wb_src_select = 2'b10; wb_rdst = 3'd7; in_port = 16'h00AA;
    step();
    n_cmp++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd7, 16'h00AA}) begin
      n_fail++; $display("FAIL wb_inport: got %b/%0d/%h want 1/7/00aa", rf_write_enable, rf_write_addr, rf_write_data);
    end
    wb_src_select = 2'b11; wb_rdst = 3'd1;
    step();
    wb_valid = 0;
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL wb_reserved: got %b want 0", rf_write_enable);
    end
  endtask

  task automatic test_ret();
    pop_start = 1; pop_kind = 0;
    step();
    pop_start = 0;
    n_cmp++;
    if ({busy, pc_load} !== 2'b10) begin
      n_fail++; $display("FAIL ret_busy0: got busy=%b pc_load=%b want 1/0", busy, pc_load);
    end
    mem_data_valid = 1; mem_data = 16'hABCD;
    step();
    n_cmp++;
    if ({busy, pc_load} !== 2'b10) begin
      n_fail++; $display("FAIL ret_busy1: got busy=%b pc_load=%b want 1/0", busy, pc_load);
    end
    mem_data = 16'hDCBA;
    step();
    mem_data_valid = 0;
    n_cmp++;
    if ({pc_load, busy, flags_load, pc_value} !== {3'b100, 32'hDCBAABCD}) begin
      n_fail++; $display("FAIL ret_done: got pc_load=%b busy=%b fl=%b pc=%h want 1/0/0/dcbaabcd", pc_load, busy, flags_load, pc_value);
    end
    step();
    n_cmp++;
    if ({pc_load, pc_value} !== {1'b0, 32'hDCBAABCD}) begin
      n_fail++; $display("FAIL ret_hold: got pc_load=%b pc=%h want 0/dcbaabcd", pc_load, pc_value);
    end
  endtask

  task automatic test_rti();
    pop_start = 1; pop_kind = 1;
    step();
    pop_start = 0;
    mem_data_valid = 1; mem_data = 16'h0007;
    step();
    mem_data = 16'hABCD;
    step();
    mem_data_valid = 0; mem_data = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({busy, pc_load, flags_load} !== 3'b100) begin
        n_fail++; $display("FAIL rti_gap%0d: got busy=%b pc_load=%b fl=%b want 1/0/0", i, busy, pc_load, flags_load);
      end
    end
    mem_data_valid = 1; mem_data = 16'hDCBA;
    step();
    mem_data_valid = 0;
    n_cmp++;
    if ({pc_load, flags_load, busy, pc_value, flags_value} !== {3'b110, 32'hDCBAABCD, 3'b111}) begin
      n_fail++; $display("FAIL rti_done: got pl=%b fl=%b busy=%b pc=%h f=%b want 1/1/0/dcbaabcd/111", pc_load, flags_load, busy, pc_value, flags_value);
    end
    step();
    n_cmp++;
    if ({pc_load, flags_load, flags_value} !== {2'b00, 3'b111}) begin
      n_fail++; $display("FAIL rti_hold: got pl=%b fl=%b f=%b want 0/0/111", pc_load, flags_load, flags_value);
    end
  endtask

  task automatic test_boundary();
    mem_data_valid = 1; mem_data = 16'h1111;
    step();
    mem_data_valid = 0;
    n_cmp++;
    if ({busy, pc_load, flags_load} !== 3'b000) begin
      n_fail++; $display("FAIL idle_valid: got busy=%b pl=%b fl=%b want 0/0/0", busy, pc_load, flags_load);
    end
    pop_start = 1; pop_kind = 0;
    step();
    pop_start = 0;
    mem_data_valid = 1; mem_data = 16'hABCD;
    step();
    mem_data_valid = 0; wb_valid = 1; wb_src_select = 2'b00; wb_rdst = 3'd3;
    alu_result = 16'h7777; pop_start = 1; pop_kind = 1;
    step();
    wb_valid = 0; pop_start = 0;
    n_cmp++;
    if ({rf_write_enable, busy, pc_load} !== 3'b010) begin
      n_fail++; $display("FAIL busy_ignore: got we=%b busy=%b pl=%b want 0/1/0", rf_write_enable, busy, pc_load);
    end
    reset = 1; mem_data_valid = 1; mem_data = 16'h9999;
    step();
    reset = 0; mem_data_valid = 0;
    n_cmp++;
    if ({busy, pc_load, flags_load} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b pl=%b fl=%b want 0/0/0", busy, pc_load, flags_load);
    end
    step();
    n_cmp++;
    if ({busy, pc_load} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b pl=%b want 0/0", busy, pc_load);
    end
    pop_start = 1; pop_kind = 0;
    step();
    pop_start = 0; mem_data_valid = 1; mem_data = 16'h5678;
    step();
    mem_data = 16'h1234;
    step();
    mem_data_valid = 0;
    n_cmp++;
    if ({pc_load, flags_load, busy, pc_value} !== {3'b100, 32'h12345678}) begin
      n_fail++; $display("FAIL ret_after_reset: got pl=%b fl=%b busy=%b pc=%h want 1/0/0/12345678", pc_load, flags_load, busy, pc_value);
    end
  endtask

  task automatic test_back_to_back();
    pop_start = 1; pop_kind = 1;
    step();
    pop_start = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    mem_data_valid = 1; mem_data = 16'h0002;
    step();
    mem_data = 16'h0000;
    step();
    mem_data = 16'hFFFF;
    step();
    mem_data_valid = 0;
    n_cmp++;
    if ({pc_load, flags_load, busy, pc_value, flags_value} !== {3'b110, 32'hFFFF0000, 3'b010}) begin
      n_fail++; $display("FAIL b2b_rti: got pl=%b fl=%b busy=%b pc=%h f=%b want 1/1/0/ffff0000/010", pc_load, flags_load, busy, pc_value, flags_value);
    end
    pop_start = 1; pop_kind = 0; wb_valid = 1; wb_src_select = 2'b01; wb_rdst = 3'd4;
    step();
    pop_start = 0; wb_valid = 0;
    n_cmp++;
    if ({rf_write_enable, busy} !== 2'b01) begin
      n_fail++; $display("FAIL pop_wins: got we=%b busy=%b want 0/1", rf_write_enable, busy);
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_ret();
    test_rti();
    test_boundary();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage; consumes its 16-bit read data and the forwarded ALU/input-port values.
- Performs normal register-file write-back.
- Runs a small sequencer that reassembles multi-word stack pops into a 32-bit PC and 3-bit flags:
  - RET pops 2 words.
  - RTI pops 3 words.
- Drives PC/flags reload and a stall to the hazard unit while a sequence is in progress.

Parameters:
- DATA_WIDTH, 16, memory word and register width.
- PC_WIDTH, 32, program counter width; must equal 2*DATA_WIDTH.
- REG_ADDR_WIDTH, 3, register-file address width (8 registers).
- FLAG_WIDTH, 3, flags width, held in mem word bits [FLAG_WIDTH-1:0].

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  normal write-back request this cycle
- wb_src_select  in  2  00=alu_result, 01=mem_data, 10=in_port, 11=reserved (no write)
- wb_rdst  in  REG_ADDR_WIDTH  destination register
- alu_result  in  DATA_WIDTH  execute result via buffers
- mem_data  in  DATA_WIDTH  memory stage read/pop data
- in_port  in  DATA_WIDTH  input port value
- pop_start  in  1  one-cycle pulse starting a pop sequence
- pop_kind  in  1  0=RET, 1=RTI; sampled with pop_start
- mem_data_valid  in  1  mem_data holds the next popped word
- rf_write_enable  out  1  register-file write strobe
- rf_write_addr  out  REG_ADDR_WIDTH  register-file address
- rf_write_data  out  DATA_WIDTH  register-file data
- pc_load  out  1  one-cycle strobe: load pc_value into PC
- pc_value  out  PC_WIDTH  reassembled PC
- flags_load  out  1  one-cycle strobe: load flags_value
- flags_value  out  FLAG_WIDTH  restored flags
- busy  out  1  pop sequence in progress; hazard unit stalls upstream

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Internal PC-low and flags holding registers cleared.
- All outputs are registered: 1-cycle latency from sampled inputs.
- Normal write-back (IDLE only):
  - If wb_valid and wb_src_select != 11: next cycle rf_write_enable=1, rf_write_addr=wb_rdst, rf_write_data=selected source.
  - Otherwise rf_write_enable=0.
  - rf_write_enable is a single-cycle strobe per accepted request.
- FSM states: IDLE, POP_FLAGS, POP_PC_LO, POP_PC_HI.
- Transitions:
  - IDLE + pop_start: pop_kind=1 -> POP_FLAGS; pop_kind=0 -> POP_PC_LO.
  - POP_FLAGS + mem_data_valid: capture mem_data[FLAG_WIDTH-1:0] -> POP_PC_LO.
  - POP_PC_LO + mem_data_valid: capture low half -> POP_PC_HI.
  - POP_PC_HI + mem_data_valid: pc_value={mem_data, captured low}, pc_load=1 next cycle, -> IDLE.
  - For RTI, flags_value/flags_load are driven in the same cycle as pc_load. For RET, flags_load=0.
  - Without mem_data_valid the FSM holds its state indefinitely; no timeout.
- Pop order is fixed: flags (RTI only), then PC[15:0], then PC[31:16]. The memory stage pushes in the reverse order.
- busy:
  - 1 in every non-IDLE state.
  - Asserted the cycle after pop_start is accepted.
  - Deasserted in the cycle pc_load is asserted.
- pc_value and flags_value hold their last values after the strobes drop.
- Boundary conditions:
  - pop_start while busy: ignored.
  - wb_valid while busy: ignored, no register write.
  - mem_data_valid in IDLE: ignored.
  - pop_start and wb_valid together in IDLE: pop wins, write-back dropped (the hazard unit never issues both).
  - reset mid-sequence: FSM to IDLE, partial words discarded, no pc_load/flags_load, busy=0 next cycle.
  - Back-to-back: a pop_start in the cycle after returning to IDLE is accepted.

Test Plan:
- Reset, then wb_valid=1, src=00, rdst=5, alu_result=16'h1234 -> next cycle rf_write_enable=1, addr=5, data=16'h1234; the cycle after, enable=0.
- Exercise each source in turn:
  - src=01, mem_data=16'hBEEF -> data BEEF.
  - src=10, in_port=16'h00AA -> data 00AA.
  - src=11 -> no write.
- RET: pop_start, pop_kind=0, then mem_data_valid with 16'hABCD, then 16'hDCBA -> busy=1 for 2 cycles; pc_load pulse with pc_value=32'hDCBAABCD; flags_load=0.
- RTI: flags word 16'h0007, then ABCD, gap of 2 cycles with valid=0, then DCBA:
  - FSM waits through the gap.
  - pc_load and flags_load pulse together with pc_value=32'hDCBAABCD, flags_value=3'b111.
- During RET, after the low word:
  - Assert wb_valid and pop_start -> both ignored.
  - Assert reset -> IDLE, busy=0, no pc_load.
  - A new RET then completes correctly.
